hilo_pipe: RTL and testbench

//  Producer side of the HI/LO interface consumed by the execute stage. Captures
//  EX-stage HI/LO write requests (hi/lo/whilo) and carries them through the
//  EX/MEM and MEM/WB pipeline registers. Commits them to the architectural HI/LO

---
 rtl/hilo_pipe_pkg.sv | 20 ++
 rtl/hilo_pipe_if.sv | 38 +++
 rtl/hilo_pipe_stage_reg.sv | 38 +++
 rtl/hilo_pipe.sv | 64 ++++++
 tb/tb_hilo_pipe.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pipe_pkg.sv
// Shared constants for the HI/LO pipeline slice: bus widths, enable levels, stall bit indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pipe_pkg;

    // Register-bus width used by the datapath
    localparam int REG_BUS_W = 32;
    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    // Legacy control levels
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;
    localparam reg_bus_t ZeroWord = '0;

    // Bit positions inside the 2-bit stall vector
    localparam int STALL_EX  = 0;
    localparam int STALL_MEM = 1;

endpackage

// File: rtl/hilo_pipe_if.sv
// Groups the HI/LO write requests from execute and the forwarding/commit results back to it.
// Latency: n/a (wiring only).
// Backpressure: stall/flush come from pipeline control; there is no ready path.
interface hilo_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [1:0]        stall_i;
    logic              flush_i;
    logic [DATA_W-1:0] ex_hi_i;
    logic [DATA_W-1:0] ex_lo_i;
    logic              ex_whilo_i;
    logic [DATA_W-1:0] mem_hi_o;
    logic [DATA_W-1:0] mem_lo_o;
    logic              mem_whilo_o;
    logic [DATA_W-1:0] wb_hi_o;
    logic [DATA_W-1:0] wb_lo_o;
    logic              wb_whilo_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [CNT_W-1:0]  wr_cnt_o;

    // Pipeline control and execute side
    modport master (
        output stall_i, flush_i, ex_hi_i, ex_lo_i, ex_whilo_i,
        input  mem_hi_o, mem_lo_o, mem_whilo_o,
        input  wb_hi_o, wb_lo_o, wb_whilo_o,
        input  hi_o, lo_o, wr_cnt_o
    );

    // HI/LO pipeline block
    modport slave (
        input  stall_i, flush_i, ex_hi_i, ex_lo_i, ex_whilo_i,
        output mem_hi_o, mem_lo_o, mem_whilo_o,
        output wb_hi_o, wb_lo_o, wb_whilo_o,
        output hi_o, lo_o, wr_cnt_o
    );
endinterface

// File: rtl/hilo_pipe_stage_reg.sv
// One {hi,lo,whilo} pipeline register with bubble/load/hold control.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: bubble beats load; neither asserted holds the current contents.
module hilo_stage_reg
    import hilo_pipe_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] d_hi,
    input  logic [DATA_W-1:0] d_lo,
    input  logic              d_whilo,
    output logic [DATA_W-1:0] q_hi,
    output logic [DATA_W-1:0] q_lo,
    output logic              q_whilo
);

    // Stage register: a bubble zeroes data too so forwarded data is 0 whenever invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            q_hi    <= '0;
            q_lo    <= '0;
            q_whilo <= WriteDisable;
        end else if (bubble) begin
            q_hi    <= '0;
            q_lo    <= '0;
            q_whilo <= WriteDisable;
        end else if (load) begin
            q_hi    <= d_hi;
            q_lo    <= d_lo;
            q_whilo <= d_whilo;
        end
    end

endmodule

// File: rtl/hilo_pipe.sv
// Carries HI/LO writes through EX/MEM and MEM/WB and commits them to the architectural HI/LO.
// Latency: request at edge N -> mem_* after N, wb_* after N+1, hi_o/lo_o after N+2.
// Backpressure: stall holds or bubbles the stage registers; commit is never blocked.
module hilo_pipe
    import hilo_pipe_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    hilo_pipe_if.slave  bus
);

    logic em_load, em_bubble;
    logic mw_bubble;

    // EX/MEM: a stalled MEM always holds, so an illegal 2'b10 behaves as 2'b11 and nothing is lost
    assign em_bubble = bus.flush_i | (bus.stall_i[STALL_EX] & ~bus.stall_i[STALL_MEM]);
    assign em_load   = ~bus.stall_i[STALL_EX] & ~bus.stall_i[STALL_MEM];

    // MEM/WB: a stalled MEM hands a bubble to WB, otherwise always advances
    assign mw_bubble = bus.flush_i | bus.stall_i[STALL_MEM];

    hilo_stage_reg #(.DATA_W(DATA_W)) u_ex_mem (
        .clk     (clk),
        .rst     (rst),
        .load    (em_load),
        .bubble  (em_bubble),
        .d_hi    (bus.ex_hi_i),
        .d_lo    (bus.ex_lo_i),
        .d_whilo (bus.ex_whilo_i),
        .q_hi    (bus.mem_hi_o),
        .q_lo    (bus.mem_lo_o),
        .q_whilo (bus.mem_whilo_o)
    );

    hilo_stage_reg #(.DATA_W(DATA_W)) u_mem_wb (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b1),
        .bubble  (mw_bubble),
        .d_hi    (bus.mem_hi_o),
        .d_lo    (bus.mem_lo_o),
        .d_whilo (bus.mem_whilo_o),
        .q_hi    (bus.wb_hi_o),
        .q_lo    (bus.wb_lo_o),
        .q_whilo (bus.wb_whilo_o)
    );

    // Commit: WB is past the exception point, so stall/flush never gate it; counter wraps freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            bus.hi_o     <= '0;
            bus.lo_o     <= '0;
            bus.wr_cnt_o <= '0;
        end else if (bus.wb_whilo_o == WriteEnable) begin
            bus.hi_o     <= bus.wb_hi_o;
            bus.lo_o     <= bus.wb_lo_o;
            bus.wr_cnt_o <= bus.wr_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed self-checking bench for hilo_pipe.
// Latency: n/a.
// Backpressure: n/a.
module tb_hilo_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] exp_cnt = 16'd0;

    hilo_pipe_if #(.DATA_W(32), .CNT_W(16)) bus ();

    hilo_pipe #(.DATA_W(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] h, input logic [31:0] l);
        bus.ex_whilo_i = w;
        bus.ex_hi_i    = h;
        bus.ex_lo_i    = l;
    endtask

    task automatic test_reset();
        logic [211:0] all_out;
        step();
        all_out = {bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o, bus.wb_whilo_o, bus.wb_hi_o,
                   bus.wb_lo_o, bus.hi_o, bus.lo_o, bus.wr_cnt_o};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", all_out);
        end
        rst = 1'b0;
        drive(1'b1, 32'h11, 32'h22);
        step(); step(); step();
        checks++;
        if ({bus.mem_whilo_o, bus.wb_whilo_o, bus.hi_o, bus.lo_o} !== {1'b1, 1'b1, 32'h11, 32'h22}) begin
            failures++;
            $display("FAIL reset_prefill got=%b %b %h %h want=1 1 11 22",
                     bus.mem_whilo_o, bus.wb_whilo_o, bus.hi_o, bus.lo_o);
        end
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #2;
        all_out = {bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o, bus.wb_whilo_o, bus.wb_hi_o,
                   bus.wb_lo_o, bus.hi_o, bus.lo_o, bus.wr_cnt_o};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", all_out);
        end
        step(); step();
        rst = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic test_single();
        drive(1'b1, 32'hDEADBEEF, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if ({bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL single_mem got=%b %h %h want=1 deadbeef 0", bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o);
        end
        step();
        checks++;
        if ({bus.mem_whilo_o, bus.wb_whilo_o, bus.wb_hi_o, bus.hi_o} !== {1'b0, 1'b1, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL single_wb got=%b %b %h %h want=0 1 deadbeef 0",
                     bus.mem_whilo_o, bus.wb_whilo_o, bus.wb_hi_o, bus.hi_o);
        end
        step();
        exp_cnt++;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.wr_cnt_o, bus.wb_whilo_o} !== {32'hDEADBEEF, 32'h0, exp_cnt, 1'b0}) begin
            failures++;
            $display("FAIL single_commit got=%h %h %0d %b want=deadbeef 0 %0d 0",
                     bus.hi_o, bus.lo_o, bus.wr_cnt_o, bus.wb_whilo_o, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // Expected mem/wb/arch per cycle: A=(1,2) B=(3,4) C=(5,6)
        logic [31:0] e_mem [5];
        logic [31:0] e_wb  [5];
        logic [31:0] e_hi  [5];
        e_mem = '{32'h1, 32'h3, 32'h5, 32'h0, 32'h0};
        e_wb  = '{32'hDEADBEEF, 32'h1, 32'h3, 32'h5, 32'h0};
        e_hi  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 32'h3, 32'h5};
        e_wb[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 32'(2*i+1), 32'(2*i+2));
            else       drive(1'b0, 32'h0, 32'h0);
            step();
            checks++;
            if ({bus.mem_hi_o, bus.wb_hi_o, bus.hi_o} !== {e_mem[i], e_wb[i], e_hi[i]}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got mem=%h wb=%h hi=%h want mem=%h wb=%h hi=%h",
                         i, bus.mem_hi_o, bus.wb_hi_o, bus.hi_o, e_mem[i], e_wb[i], e_hi[i]);
            end
        end
        exp_cnt += 16'd3;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.wr_cnt_o} !== {32'h5, 32'h6, exp_cnt}) begin
            failures++;
            $display("FAIL b2b_final got=%h %h %0d want=5 6 %0d", bus.hi_o, bus.lo_o, bus.wr_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h7, 32'h8);
        step();
        bus.stall_i = 2'b11;
        drive(1'b1, 32'hBAD, 32'hBAD);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o, bus.wb_whilo_o} !== {1'b1, 32'h7, 32'h8, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b %h %h wb=%b want=1 7 8 wb=0",
                         i, bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o, bus.wb_whilo_o);
            end
        end
        bus.stall_i = 2'b00;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        exp_cnt++;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.wr_cnt_o} !== {32'h7, 32'h8, exp_cnt}) begin
            failures++;
            $display("FAIL stall_commit got=%h %h %0d want=7 8 %0d", bus.hi_o, bus.lo_o, bus.wr_cnt_o, exp_cnt);
        end
        // EX-only stall: EX/MEM takes a bubble, MEM/WB still advances
        drive(1'b1, 32'h17, 32'h18);
        step();
        bus.stall_i = 2'b01;
        drive(1'b1, 32'hBAD, 32'hBAD);
        step();
        checks++;
        if ({bus.mem_whilo_o, bus.mem_hi_o, bus.wb_whilo_o, bus.wb_hi_o, bus.wb_lo_o} !==
            {1'b0, 32'h0, 1'b1, 32'h17, 32'h18}) begin
            failures++;
            $display("FAIL stall_ex_bubble got mem=%b %h wb=%b %h %h want mem=0 0 wb=1 17 18",
                     bus.mem_whilo_o, bus.mem_hi_o, bus.wb_whilo_o, bus.wb_hi_o, bus.wb_lo_o);
        end
        bus.stall_i = 2'b00;
        drive(1'b0, 32'h0, 32'h0);
        step();
        exp_cnt++;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.wr_cnt_o} !== {32'h17, 32'h18, exp_cnt}) begin
            failures++;
            $display("FAIL stall_ex_commit got=%h %h %0d want=17 18 %0d", bus.hi_o, bus.lo_o, bus.wr_cnt_o, exp_cnt);
        end
        // Illegal 2'b10 must hold EX/MEM, never load
        drive(1'b1, 32'h27, 32'h28);
        step();
        bus.stall_i = 2'b10;
        drive(1'b1, 32'hBAD, 32'hBAD);
        step();
        checks++;
        if ({bus.mem_whilo_o, bus.mem_hi_o, bus.wb_whilo_o} !== {1'b1, 32'h27, 1'b0}) begin
            failures++;
            $display("FAIL stall_illegal got mem=%b %h wb=%b want mem=1 27 wb=0",
                     bus.mem_whilo_o, bus.mem_hi_o, bus.wb_whilo_o);
        end
        bus.stall_i = 2'b00;
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        exp_cnt++;
        checks++;
        if ({bus.hi_o, bus.wr_cnt_o} !== {32'h27, exp_cnt}) begin
            failures++;
            $display("FAIL stall_illegal_commit got=%h %0d want=27 %0d", bus.hi_o, bus.wr_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hA, 32'hA);
        step();
        drive(1'b1, 32'h9, 32'h9);
        step();
        bus.flush_i = 1'b1;
        drive(1'b1, 32'hBAD, 32'hBAD);
        step();
        exp_cnt++;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.wr_cnt_o, bus.mem_whilo_o, bus.mem_hi_o, bus.wb_whilo_o, bus.wb_hi_o} !==
            {32'hA, 32'hA, exp_cnt, 1'b0, 32'h0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL flush_edge got hi=%h lo=%h cnt=%0d mem=%b %h wb=%b %h want hi=a lo=a cnt=%0d mem=0 0 wb=0 0",
                     bus.hi_o, bus.lo_o, bus.wr_cnt_o, bus.mem_whilo_o, bus.mem_hi_o,
                     bus.wb_whilo_o, bus.wb_hi_o, exp_cnt);
        end
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        checks++;
        if ({bus.hi_o, bus.wr_cnt_o} !== {32'hA, exp_cnt}) begin
            failures++;
            $display("FAIL flush_no_leak got=%h %0d want=a %0d", bus.hi_o, bus.wr_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 65535 - int'(exp_cnt);
        drive(1'b1, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            bus.ex_hi_i = 32'(i);
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        checks++;
        if ({bus.wr_cnt_o, bus.hi_o} !== {16'hFFFF, 32'(n-1)}) begin
            failures++;
            $display("FAIL wrap_preload got=%h %h want=ffff %h", bus.wr_cnt_o, bus.hi_o, 32'(n-1));
        end
        drive(1'b1, 32'hC0FFEE, 32'h5A5A);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        checks++;
        if ({bus.wr_cnt_o, bus.hi_o, bus.lo_o} !== {16'h0000, 32'hC0FFEE, 32'h5A5A}) begin
            failures++;
            $display("FAIL wrap_rollover got=%h %h %h want=0 c0ffee 5a5a", bus.wr_cnt_o, bus.hi_o, bus.lo_o);
        end
    endtask

    initial begin
        bus.stall_i = 2'b00;
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
